// File: rtl/apb_pkg.sv
// Shared types and constants for the APB3 requester.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // Read data returned when a completer never raises PREADY.
    localparam logic [31:0] APB_TIMEOUT_RDATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

endpackage

// File: rtl/apb3_master.sv
// APB3 requester: one command at a time, SETUP/ACCESS sequencing, PREADY wait
// with a bounded timeout, response held on a valid/ready port until consumed.
module apb3_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    apb_state_e        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                state_d   = SETUP;
                paddr_d   = cmd_addr;
                pwrite_d  = cmd_write;
                pwdata_d  = cmd_wdata;
                psel_d    = 1'b1;
                penable_d = 1'b0;
                cnt_d     = '0;
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // PREADY takes priority over a timeout landing in the same cycle.
                if (PREADY || timeout_hit) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    if (!PREADY) begin
                        rsp_rdata_d   = DATA_W'(APB_TIMEOUT_RDATA);
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: if (rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb3_master.sv
// Randomized bench for apb3_master: a completer model with programmable wait
// states, checked against transfer-level expectations (latency, data, errors).
module tb_apb3_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;

    int n_chk = 0;
    int n_err = 0;

    apb3_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transfer; entered and left just after a falling edge.
    // waits = ACCESS cycles the completer holds PREADY low before raising it.
    task automatic run_txn(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                           input int waits, input logic [DW-1:0] rd, input logic err,
                           input int bp);
        int  cyc, acc, rsp_cyc, exp_acc;
        bit  timed;
        logic [DW-1:0] exp_rd;
        logic [DW-1:0] held;
        timed   = (TO != 0) && (waits >= TO);
        exp_acc = timed ? TO : waits + 1;
        exp_rd  = timed ? 32'hDEADBEEF : (w ? '0 : rd);

        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_wdata = wd;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_write = 1'($urandom); cmd_wdata = $urandom;

        cyc = 0; acc = 0; rsp_cyc = 0;
        while (rsp_cyc == 0 && cyc < 100) begin
            @(negedge PCLK);
            cyc++;
            if (rsp_valid) begin
                rsp_cyc = cyc;
            end else begin
                if (cyc == 1) begin
                    chk("setup_psel", PSEL, 1);
                    chk("setup_penable", PENABLE, 0);
                end
                if (PSEL) begin
                    chk("paddr_stable", PADDR, a);
                    chk("pwrite_stable", PWRITE, w);
                    chk("pwdata_stable", PWDATA, wd);
                end
                if (PSEL && PENABLE) begin
                    PREADY  = (acc == waits);
                    PSLVERR = (acc == waits) ? err : 1'b1;
                    PRDATA  = (acc == waits) ? rd : $urandom;
                    acc++;
                end else begin
                    PREADY = 1'b0; PSLVERR = 1'b0;
                end
            end
        end
        PREADY = 1'b0; PSLVERR = 1'b0;
        chk("rsp_latency", rsp_cyc, 2 + exp_acc);
        chk("access_cycles", acc, exp_acc);
        chk("rsp_psel", PSEL, 0);
        chk("rsp_penable", PENABLE, 0);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", rsp_err, timed ? 1'b1 : err);
        chk("rsp_timeout", rsp_timeout, timed);
        chk("paddr_kept", PADDR, a);
        chk("pwdata_kept", PWDATA, wd);
        held = rsp_rdata;

        for (int i = 0; i < bp; i++) begin
            cmd_valid = 1'b1; cmd_addr = $urandom;
            @(negedge PCLK);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_rdata", rsp_rdata, held);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_psel", PSEL, 0);
        end
        rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        rsp_ready = 1'b0; cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("rsp_drop", rsp_valid, 0);
        chk("idle_ready", cmd_ready, 1);
    endtask

    initial begin
        int  seen;
        PRESET = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
        rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", {rsp_err, rsp_timeout}, 0);
        chk("rst_cmd_ready", cmd_ready, 1);

        run_txn(32'h0, 1'b1, 32'h1234_5678, 0, 32'h0, 1'b0, 0);        // zero-wait write
        run_txn(32'h1, 1'b0, 32'h0, 3, 32'hCAFE_F00D, 1'b0, 0);        // wait-state read
        run_txn(32'h2, 1'b0, 32'h0, 0, 32'h5555_AAAA, 1'b1, 0);        // slave error
        run_txn(32'h3, 1'b0, 32'h0, 2, 32'h0BAD_0BAD, 1'b0, 0);        // PSLVERR only in waits
        run_txn(32'h4, 1'b0, 32'h0, TO, 32'h1111_2222, 1'b0, 0);       // timeout
        run_txn(32'h5, 1'b1, 32'h7777_8888, TO + 5, 32'h0, 1'b0, 1);   // timeout on a write
        run_txn(32'h6, 1'b0, 32'h0, TO - 1, 32'h3333_4444, 1'b0, 0);   // PREADY on final cycle
        run_txn(32'h7, 1'b1, 32'h9999_0000, 1, 32'h0, 1'b0, 5);        // backpressure
        run_txn(32'h8, 1'b0, 32'h0, 0, 32'hABCD_EF01, 1'b0, 0);        // back-to-back

        // Reset while the completer is stalling.
        cmd_valid = 1'b1; cmd_addr = 32'h40; cmd_write = 1'b1; cmd_wdata = 32'h55;
        @(posedge PCLK); #1 cmd_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("pre_rst_access", {PSEL, PENABLE}, 2'b11);
        PRESET = 1'b1;
        @(posedge PCLK); #1 PRESET = 1'b0; PREADY = 1'b1;
        @(negedge PCLK);
        chk("mid_rst_psel", PSEL, 0);
        chk("mid_rst_penable", PENABLE, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (rsp_valid || PSEL) seen++;
        end
        chk("mid_rst_no_rsp", seen, 0);
        PREADY = 1'b0;

        for (int t = 0; t < 40; t++) begin
            run_txn($urandom, 1'($urandom), $urandom, $urandom_range(0, TO + 3),
                    $urandom, 1'($urandom), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/apb3_master.md
Name: apb3_master

Overview:
- APB3 requester that drives the PSEL/PENABLE/PADDR bus toward APB3 completers, such as the config-register slaves.
- Accepts single commands on a valid/ready request port and runs the SETUP then ACCESS phases.
- Waits on PREADY and returns PRDATA/PSLVERR on a valid/ready response port.
- A bounded wait-state timeout recovers the bus from a hung completer.

Parameters:
- ADDR_W, 32, PADDR and cmd_addr width.
- DATA_W, 32, PWDATA/PRDATA/cmd_wdata/rsp_rdata width.
- TIMEOUT, 16, ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  request valid.
- cmd_ready  out  1  request accepted when high together with cmd_valid.
- cmd_addr  in  ADDR_W  target address.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data.
- rsp_err  out  1  PSLVERR or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PADDR  out  ADDR_W  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  completer ready.
- PSLVERR  in  1  completer error.

Behaviour:
- Registered outputs: all outputs are registered except cmd_ready, which equals (state==IDLE).
- Reset (PRESET high at a PCLK edge): state=IDLE; PSEL, PENABLE, PWRITE, rsp_valid, rsp_err and rsp_timeout = 0; PADDR, PWDATA and rsp_rdata = 0; wait counter = 0.
- Reset mid-transfer: aborts immediately with no response; the next cycle shows PSEL=0.
- IDLE -> SETUP: when cmd_valid=1 at the edge.
  - cmd_addr/cmd_write/cmd_wdata are latched into PADDR/PWRITE/PWDATA.
  - PSEL=1, PENABLE=0.
- SETUP -> ACCESS: unconditional after one cycle; PENABLE=1.
- ACCESS with PREADY=0: stay in ACCESS and increment the counter.
  - PADDR/PWRITE/PWDATA/PSEL/PENABLE are held stable.
- ACCESS with PREADY=1: go to RESP.
  - Read: rsp_rdata <= PRDATA.
  - Write: rsp_rdata <= 0.
  - rsp_err <= PSLVERR, rsp_timeout <= 0, rsp_valid <= 1.
  - PSEL <= 0, PENABLE <= 0.
- Timeout: TIMEOUT != 0 and the counter reaches TIMEOUT-1 with PREADY=0.
  - Same exit as a PREADY=1 completion, but rsp_rdata <= 32'hDEADBEEF (truncated/zero-extended to DATA_W), rsp_err <= 1, rsp_timeout <= 1.
- PREADY and timeout in the same cycle: PREADY wins, so it is a normal completion.
- RESP: hold rsp_* stable until rsp_ready=1 at an edge, then go to IDLE and set rsp_valid <= 0.
- Counter: cleared on entering SETUP; width is clog2(TIMEOUT+1), minimum 1.
- Latency with zero wait states: command accepted at edge N, PSEL=1 after N, PENABLE=1 after N+1, rsp_valid=1 after N+2.
  - Minimum issue interval is 4 cycles (IDLE, SETUP, ACCESS, RESP).
- PADDR/PWRITE/PWDATA keep their last values after a transfer; they are not cleared.
- PSLVERR is sampled only when PREADY=1 in ACCESS.
- PRDATA is ignored for writes.

Decomposition:
- Package apb_pkg:
  - state enum apb_state_e {IDLE, SETUP, ACCESS, RESP}.
  - Constant APB_TIMEOUT_RDATA = 32'hDEADBEEF.
  - Default ADDR_W/DATA_W localparams.
- No sub-module. The FSM, wait counter and response register stay in the single module.

Test Plan:
- Zero-wait write: cmd addr=0, wdata=0x1234_5678, write=1, PREADY tied 1.
  - PSEL rises 1 cycle after accept, PENABLE 1 cycle later.
  - rsp_valid 3 cycles after accept with rsp_err=0 and rsp_rdata=0.
  - PADDR/PWDATA stable across SETUP and ACCESS.
- Wait-state read: addr=1, completer holds PREADY low for 3 ACCESS cycles, then PRDATA=0xCAFEF00D with PREADY=1.
  - PENABLE high for 4 cycles.
  - rsp_rdata=0xCAFEF00D, rsp_err=0.
- Slave error: read with PREADY=1 and PSLVERR=1.
  - rsp_err=1, rsp_timeout=0.
  - PSLVERR high while PREADY=0 in an earlier wait cycle does not set rsp_err.
- Timeout: TIMEOUT=16, PREADY held 0.
  - Exactly 16 ACCESS cycles, then PSEL=0.
  - rsp_rdata=0xDEADBEEF, rsp_err=1, rsp_timeout=1.
  - With PREADY=1 on the 16th cycle: normal completion instead.
- Backpressure and back-to-back: rsp_ready low for 5 cycles with cmd_valid held high.
  - cmd_ready stays 0 and rsp_* stays stable.
  - After the rsp_ready handshake the next command is accepted the following cycle.
- Reset mid-ACCESS: PRESET pulsed with PREADY=0.
  - Next cycle: PSEL=0, PENABLE=0, rsp_valid=0, cmd_ready=1, and no response is ever issued.
